// File: rtl/pipe_stage_elastic.sv
// Elastic valid/ready pipeline stage with an optional skid slot and req/flush kill.
// Also keeps an optional bubble PC and saturating stall/bubble counters.
module pipe_stage_elastic #(
  parameter int DATA_W       = 32,
  parameter int PC_W         = 32,
  parameter int EXC_W        = 5,
  parameter int SKID         = 1,
  parameter int PC_ON_BUBBLE = 1,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [DATA_W-1:0] in_data,
  input  logic [EXC_W-1:0]  in_exc,
  input  logic              in_bd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [DATA_W-1:0] out_data,
  output logic [EXC_W-1:0]  out_exc,
  output logic              out_bd,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam bit HAS_SKID = (SKID != 0);
  localparam bit KEEP_PC  = (PC_ON_BUBBLE != 0);

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] data;
    logic [EXC_W-1:0]  exc;
    logic              bd;
  } ent_t;

  logic             r_m_vld, r_s_vld;
  ent_t             r_m, r_s;
  logic [CNT_W-1:0] r_stall, r_bubble;

  ent_t w_in, w_bub_ent;
  logic w_in_fire, w_m_free;

  // The skid variant derives in_ready from state only, so out_ready never reaches it.
  always_comb begin
    if (HAS_SKID) in_ready = !r_s_vld;
    else          in_ready = !r_m_vld | out_ready;
  end

  assign w_in_fire = in_valid & in_ready;
  assign w_m_free  = !r_m_vld | out_ready;
  assign w_in      = '{pc: in_pc, data: in_data, exc: in_exc, bd: in_bd};

  // Bubble entry: payload zeroed, PC optionally kept. S valid implies M valid,
  // so M is always the oldest entry whenever anything is killed or drained.
  always_comb begin
    w_bub_ent = '0;
    if (KEEP_PC) w_bub_ent.pc = r_m.pc;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_m_vld <= 1'b0;
      r_m     <= '0;
      r_s_vld <= 1'b0;
      r_s     <= '0;
    end else if (req) begin
      r_m_vld <= 1'b0;
      r_m     <= '0;
      r_s_vld <= 1'b0;
      r_s     <= '0;
    end else if (flush) begin
      r_m_vld <= 1'b0;
      r_m     <= w_bub_ent;
      r_s_vld <= 1'b0;
      r_s     <= '0;
    end else if (w_m_free) begin
      if (r_s_vld) begin
        r_m_vld <= 1'b1;
        r_m     <= r_s;
        r_s_vld <= 1'b0;
        r_s     <= '0;
      end else if (w_in_fire) begin
        r_m_vld <= 1'b1;
        r_m     <= w_in;
      end else begin
        r_m_vld <= 1'b0;
        r_m     <= w_bub_ent;
      end
    end else if (HAS_SKID && w_in_fire) begin
      r_s_vld <= 1'b1;
      r_s     <= w_in;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall  <= '0;
      r_bubble <= '0;
    end else begin
      if (r_m_vld && !out_ready && !(&r_stall)) r_stall  <= r_stall + CNT_W'(1);
      if (!r_m_vld && !(&r_bubble))             r_bubble <= r_bubble + CNT_W'(1);
    end
  end

  assign out_valid  = r_m_vld;
  assign out_pc     = r_m.pc;
  assign out_data   = r_m.data;
  assign out_exc    = r_m.exc;
  assign out_bd     = r_m.bd;
  assign stall_cnt  = r_stall;
  assign bubble_cnt = r_bubble;

endmodule

// File: doc/pipe_stage_elastic.md
Name: pipe_stage_elastic

Overview:
- Parametrised successor to the fixed F/D pipeline register.
- Carries a generic payload bundle (PC, data word, exception code, branch-delay flag) between two pipeline stages using a valid/ready handshake.
- Optional one-entry skid buffer, so back-pressure is never combinational from out_ready to in_ready.
- Keeps the req (exception) and flush kill semantics, adds an optional bubble-PC retention mode, and has saturating stall and bubble performance counters.

Parameters:
DATA_W, 32, payload data width (instruction or any stage bundle)
PC_W, 32, PC width
EXC_W, 5, exception-code width
SKID, 1, 1 = two-entry skid (main + skid slot); 0 = single main slot
PC_ON_BUBBLE, 1, 1 = a flush-created bubble keeps the killed entry's PC; 0 = PC cleared
CNT_W, 16, performance counter width

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low (0 = reset)
req  in  1  exception/interrupt kill, highest synchronous priority
flush  in  1  pipeline flush kill
in_valid  in  1  upstream entry present
in_ready  out  1  stage can accept this cycle
in_pc  in  PC_W  upstream PC
in_data  in  DATA_W  upstream payload
in_exc  in  EXC_W  upstream exception code
in_bd  in  1  upstream branch-delay flag
out_valid  out  1  main slot holds a valid entry
out_ready  in  1  downstream accepts
out_pc  out  PC_W  main slot PC
out_data  out  DATA_W  main slot payload
out_exc  out  EXC_W  main slot exception code
out_bd  out  1  main slot branch-delay flag
stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0
bubble_cnt  out  CNT_W  cycles with out_valid=0

Behaviour:
Storage:
- Main slot M drives all out_* signals directly from registers.
- Skid slot S exists only when SKID=1.

Handshake:
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- SKID=1: in_ready = !S_valid, registered, with no dependence on out_ready.
- SKID=0: in_ready = !M_valid | out_ready.

Reset:
- Asserting reset (0) immediately clears M_valid, S_valid, all payload fields and both counters, mid-operation included.
- Outputs while in reset: out_valid=0, out_pc/data/exc/bd=0, stall_cnt=bubble_cnt=0, in_ready=1.

Per-edge priority: req > flush > normal.

req:
- M and S become invalid with all payload zero (PC included).
- A coincident in_fire is discarded.

flush:
- M and S become invalid; data, exc and bd are zeroed; a coincident in_fire is discarded.
- With PC_ON_BUBBLE=1, out_pc takes the PC of the oldest valid entry killed (M if valid, else S); if neither is valid, out_pc holds its current value.
- With PC_ON_BUBBLE=0, out_pc=0.

Normal, M free (M invalid or out_fire):
- If S is valid, M takes S and S empties. A concurrent in_fire is impossible because in_ready=0.
- Otherwise, if in_fire, M takes the input.
- Otherwise M becomes invalid with data/exc/bd zeroed; out_pc follows the PC_ON_BUBBLE rule above, using the departing entry.

Normal, M held (valid, not firing):
- SKID=1: an in_fire loads S.
- SKID=0: in_fire cannot occur.

Ordering and latency:
- Entries leave in acceptance order.
- Nothing accepted is lost except by req/flush.
- Latency is 1 cycle from in_fire to out_valid when M is free.
- SKID=1 sustains 1 entry/cycle throughput.

Counters:
- Saturating at all-ones.
- Sampled on the current registered out_valid/out_ready each edge.
- Cleared only by reset; req/flush do not clear them.

Invariants:
- An invalid slot always holds zero data/exc/bd.
- S_valid implies M_valid.

Test Plan:
1. Reset=0 mid-stream with M and S full → same cycle out_valid=0, in_ready=1, out_pc=0, counters=0; after release, first in_valid with pc=0x3000 gives out_valid=1, out_pc=0x3000 one edge later.
2. SKID=1, stream pc 0x3000,0x3004,0x3008 with out_ready=1 → output one per cycle in order, stall_cnt unchanged; drop out_ready for 2 cycles → 0x3004 held in M, 0x3008 captured in S, in_ready=0, stall_cnt+=2, no loss after release.
3. M=0x3010, S=0x3014, flush=1 with in_valid (pc 0x3018), PC_ON_BUBBLE=1 → out_valid=0, out_pc=0x3010, out_data=0, out_exc=0, in_ready=1, 0x3018 never appears.
4. req and flush together with M valid, exc=4, bd=1 → out_valid=0, out_pc=0, out_exc=0, out_bd=0.
5. SKID=0: out_ready=0 with M valid → in_ready=0 same cycle; out_ready=1 with in_valid → M replaced the same edge (back-to-back, no bubble).
6. CNT_W=4, hold out_valid=1 and out_ready=0 for 20 cycles → stall_cnt saturates at 15; 3 idle cycles → bubble_cnt=3.
